caesar_encryption: RTL and testbench
====================================

# caesar_encryption

Byte-stream Caesar encryptor, the transmit-side counterpart of the team's Caesar decryption block. Each plaintext word accepted on the input is shifted up by the low D_WIDTH bits of the key (mod 2^D_WIDTH), buffered in a small FIFO, and presented on a valid/ready output port with backpressure. `busy` tells the upstream source to hold its data.

## Interface
- D_WIDTH, 8: plaintext/ciphertext word width.
- KEY_WIDTH, 16: key port width. Only bits [D_WIDTH-1:0] are used.
- FIFO_DEPTH, 4: ciphertext FIFO entries. Power of two, ≥2.

Ports:
- clk  in  1: single clock. Everything is sampled on the rising edge.
- rst  in  1: reset. One clock; reset is synchronous and active-high.
- data_i  in  D_WIDTH: plaintext word.
- valid_i  in  1: data_i is valid this cycle.
- key  in  KEY_WIDTH: encryption key. Sampled at the accept edge.
- ready_i  in  1: downstream can take data_o this cycle.
- busy  out  1: FIFO full. Input is not accepted while busy is high.
- data_o  out  D_WIDTH: ciphertext word.
- valid_o  out  1: data_o holds a valid ciphertext word.

## Operation
- Accept: a word is accepted on an edge where valid_i=1 and busy=0.
  - While busy=1, valid_i is ignored. The source must hold the word.
- Cipher: ct = (data_i + key[D_WIDTH-1:0]) mod 2^D_WIDTH, computed at accept and written to the FIFO.
  - key changes affect only words accepted afterwards.
  - Decrypting with the same key recovers the plaintext.
- FIFO: count 0..FIFO_DEPTH, write/read pointers wrap mod FIFO_DEPTH. Order is preserved.
- Output register (data_o/valid_o), two implicit states:
  - EMPTY (valid_o=0) → LOADED when count>0. Head is loaded and popped.
  - LOADED with ready_i=1:
    - count>0: reload from head and pop, staying LOADED.
    - count=0: go to EMPTY.
  - LOADED with ready_i=0: hold. data_o and valid_o stay stable.
- Total storage is FIFO_DEPTH+1 words.
- busy is registered and equals (next count == FIFO_DEPTH).
- Simultaneous push and pop in one edge leaves count unchanged. A push into an empty FIFO is not bypassed to the output in the same edge.

## Timing
- Reset values:
  - busy=0, valid_o=0, data_o=0.
  - count=0, both pointers 0.
  - FIFO contents are don't-care.
- Reset has priority over every other action. Reset mid-stream drops all buffered words, and nothing is emitted after reset deasserts.
- Latency: a word accepted at edge E is written at E and loaded into the output register at E+1. It is visible on data_o/valid_o in the cycle after E+1, i.e. 2 edges from accept, the same latency as the decryptor.
- Throughput: 1 word/cycle when valid_i=1 and ready_i=1 continuously. busy never rises in that case.
- With ready_i=0 held, busy rises after the (FIFO_DEPTH+1)-th accept (the first word sits in the output register). It falls on the edge after the first pop.
- Transfer out occurs on an edge with valid_o=1 and ready_i=1.
- valid_o must not drop without a transfer.

## Structure
- Shared package caesar_pkg holds:
  - default D_WIDTH/KEY_WIDTH constants;
  - function caesar_shift(data, key, dir), where dir selects + or −;
  - so that the decryptor can reuse them.
- One sub-module, sync_fifo (params WIDTH, DEPTH; ports push, pop, wdata, rdata, count, full, empty), with the same clk/rst convention.
- Top level contains the cipher adder, the output register and the busy register.

## Test plan
- Reset, then valid_i=1, data_i=0x41, key=0x0003, ready_i=1 for 1 cycle → data_o=0x44, valid_o=1 exactly 2 edges later for 1 cycle; busy stays 0.
- Wrap: data_i=0xFE, key=0x0105 → data_o=0x03, so upper key bits are ignored.
- Backpressure: ready_i=0, push 0x10..0x15 with key=0.
  - busy=1 after the 5th accept; 0x15 is held off.
  - Then ready_i=1: outputs 0x10,0x11,0x12,0x13,0x14,0x15 in order, with no gaps once started.
  - busy falls one edge after the first transfer.
- Key change mid-stream: key=1 for 0x20, then key=2 for 0x20 → outputs 0x21 then 0x22.
- Reset mid-operation with 3 words buffered and valid_o=1 → next cycle valid_o=0, busy=0, data_o=0. No stale word appears afterward.
- Random stream with random ready_i (10k words) piped into the decryptor with the same key → recovered stream equals the input.
  - Also checks: data_o stable while valid_o=1 and ready_i=0, and no accept while busy=1.

Source files
------------

// File: rtl/caesar_pkg.sv
// caesar_pkg: shared Caesar cipher constants and shift helper for the encryptor and decryptor
package caesar_pkg;

    localparam int D_WIDTH_DEF   = 8;
    localparam int KEY_WIDTH_DEF = 16;

    typedef enum logic {DIR_ENC = 1'b0, DIR_DEC = 1'b1} dir_e;

    // Callers truncate the result to their word width, which makes it mod 2^width
    // and discards any key bits above that width.
    function automatic logic [31:0] caesar_shift(input logic [31:0] data, input logic [31:0] key, input dir_e dir);
        return dir == DIR_ENC ? data + key : data - key;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, power-of-two depth
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr];

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    // storage needs no reset; stale entries are never read
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/caesar_encryption.sv
// caesar_encryption: shifts accepted words by the key, buffers them and streams them out with backpressure
module caesar_encryption
    import caesar_pkg::*;
#(
    parameter int D_WIDTH    = D_WIDTH_DEF,
    parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 ready_i,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic               accept, pop, full, empty;
    logic [D_WIDTH-1:0] ct, head;
    logic [CW-1:0]      count, next_count;

    assign accept     = valid_i && !busy && !full;
    assign pop        = !empty && (!valid_o || ready_i);
    assign ct         = D_WIDTH'(caesar_shift(32'(data_i), 32'(key), DIR_ENC));
    assign next_count = count + CW'(accept) - CW'(pop);

    sync_fifo #(.WIDTH(D_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .wdata (ct),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // output register reloads from the FIFO head whenever it is empty or being drained; busy tracks the next count
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            busy <= next_count == CW'(FIFO_DEPTH);
            if (pop) begin
                data_o  <= head;
                valid_o <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_caesar_encryption.sv
// tb_caesar_encryption: table vectors, corner sequences and a random stream checked through a scoreboard
module tb_caesar_encryption;
    import caesar_pkg::*;

    localparam int DW = 8;
    localparam int KW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [KW-1:0] key = '0;
    logic          busy, valid_o;
    logic [DW-1:0] data_o;

    typedef struct {
        logic [7:0]  ct;
        logic [7:0]  pt;
        logic [15:0] k;
        bit          dec;
    } exp_t;

    typedef struct {
        logic [7:0]  d;
        logic [15:0] k;
        logic [7:0]  ct;
    } vec_t;

    exp_t       sbq[$];
    vec_t       vecs[8];
    int         n_cmp = 0;
    int         n_fail = 0;
    bit         rnd = 1'b0;
    bit         hold_prev = 1'b0;
    logic [7:0] prev_data = '0;

    caesar_encryption #(.D_WIDTH(DW), .KEY_WIDTH(KW), .FIFO_DEPTH(FD)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key     (key),
        .ready_i (ready_i),
        .busy    (busy),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // presents one word from posedge+1 until an edge accepts it, then records the expectation
    task automatic drive(input logic [7:0] d, input logic [15:0] k, input logic [7:0] exp_ct, input bit dec);
        int t = 0;
        bit ok = 1'b0;
        data_i  = d;
        key     = k;
        valid_i = 1'b1;
        while (!ok && t < 1000) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
            @(posedge clk);
            #1;
            if (rnd) ready_i = 1'($urandom_range(0, 1));
            t++;
        end
        valid_i = 1'b0;
        if (ok) sbq.push_back('{exp_ct, d, k, dec});
        else chk("accept_timeout", 32'(busy), 32'(0));
    endtask

    task automatic wait_empty();
        int t = 0;
        while ((sbq.size() != 0 || valid_o) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) chk("drain_timeout", 32'(sbq.size()), 32'(0));
    endtask

    // scoreboard: checks busy against occupancy, hold stability under backpressure, and each transfer
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'((sbq.size() - int'(valid_o)) == FD));
            if (hold_prev) begin
                chk("hold_valid", 32'(valid_o), 32'(1));
                chk("hold_data", 32'(data_o), 32'(prev_data));
            end
            hold_prev = valid_o && !ready_i;
            prev_data = data_o;
            if (valid_o && ready_i) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", 32'(valid_o), 32'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("ct", 32'(data_o), 32'(e.ct));
                    if (e.dec) chk("decrypt", caesar_shift(32'(data_o), 32'(e.k), DIR_DEC) & 32'hFF, 32'(e.pt));
                end
            end
        end
    end

    initial begin
        logic [7:0]  d;
        logic [15:0] k;
        vecs[0] = '{8'h41, 16'h0003, 8'h44};
        vecs[1] = '{8'hFE, 16'h0105, 8'h03};
        vecs[2] = '{8'h00, 16'h00FF, 8'hFF};
        vecs[3] = '{8'hFF, 16'h0001, 8'h00};
        vecs[4] = '{8'h80, 16'h8080, 8'h00};
        vecs[5] = '{8'h20, 16'h0001, 8'h21};
        vecs[6] = '{8'h20, 16'h0002, 8'h22};
        vecs[7] = '{8'h7F, 16'hFFFF, 8'h7E};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_valid", 32'(valid_o), 32'(0));
        chk("rst_data", 32'(data_o), 32'(0));
        @(posedge clk);
        #1;

        ready_i = 1'b1;
        drive(8'h41, 16'h0003, 8'h44, 1'b1);
        @(negedge clk);
        chk("lat_edge1_valid", 32'(valid_o), 32'(0));
        @(negedge clk);
        chk("lat_edge2_valid", 32'(valid_o), 32'(1));
        chk("lat_edge2_data", 32'(data_o), 32'(8'h44));
        @(negedge clk);
        chk("lat_edge3_valid", 32'(valid_o), 32'(0));
        @(posedge clk);
        #1;

        foreach (vecs[i]) drive(vecs[i].d, vecs[i].k, vecs[i].ct, 1'b1);
        wait_empty();

        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) drive(8'(8'h10 + i), 16'h0000, 8'(8'h10 + i), 1'b1);
        data_i  = 8'h15;
        key     = 16'h0000;
        valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_busy", 32'(busy), 32'(1));
            chk("bp_head", 32'(data_o), 32'(8'h10));
        end
        @(posedge clk);
        #1 ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_nogap", 32'(valid_o), 32'(1));
            if (i == 1) begin
                chk("bp_busy_fall", 32'(busy), 32'(0));
                @(posedge clk);
                #1 valid_i = 1'b0;
                sbq.push_back('{8'h15, 8'h15, 16'h0000, 1'b1});
            end
        end
        @(posedge clk);
        #1;
        wait_empty();

        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) drive(8'(8'h30 + i), 16'h0005, 8'(8'h35 + i), 1'b1);
        @(negedge clk);
        chk("pre_rst_valid", 32'(valid_o), 32'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(valid_o), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_data", 32'(data_o), 32'(0));
        ready_i = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(valid_o), 32'(0));
        end
        @(posedge clk);
        #1;

        rnd = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1 ready_i = 1'($urandom_range(0, 1));
            end
            d = 8'($urandom);
            k = 16'($urandom);
            drive(d, k, 8'(d + k[7:0]), 1'b1);
        end
        rnd = 1'b0;
        ready_i = 1'b1;
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
